alarm_ctrl: RTL
===============

ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameters SHALL be: CLK_HZ, 50_000_000, clk frequency; TONE_HZ, 2000, buzzer tone; RING_SEC, 60, max ring duration; SNOOZE_SEC, 300, snooze duration.
REQ-002 Ports SHALL be: clk  in  1  system clock, single clock domain, rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 e0,e1,e2,e3  in  4 each  current time BCD (min units, min tens, hour units, hour tens).
REQ-005 a  in  1  alarm-set mode level (1 = buttons edit alarm time).
REQ-006 buh, bum  in  1  hour/minute buttons, debounced upstream, level.
REQ-007 en  in  1  alarm enable switch, level.
REQ-008 stop, snz  in  1  stop/snooze buttons, debounced upstream, level.
REQ-009 a0,a1,a2,a3  out  4 each  stored alarm time BCD, same digit order as e0..e3.
REQ-010 s0,s3,s2,s3 as s0..s3  out  4 each  display digits: alarm time when a=1, else current time.
REQ-011 buzz  out  1  gated square-wave buzzer drive.
REQ-012 ringing, snoozing  out  1  state flags.

Function
REQ-013 buh, bum, stop, snz SHALL pass a 2-FF synchronizer plus rising-edge detect, giving one-cycle pulses; rise at input -> pulse acts on 3rd clk edge.
REQ-014 e0..e3 SHALL be registered once (edig); upstream holds them stable >=2 clk cycles per change.
REQ-015 bum pulse with a=1 SHALL increment a1:a0 in BCD, 09->10, 59->00, no carry into hours.
REQ-016 buh pulse with a=1 SHALL increment a3:a2 in BCD, 09->10, 19->20, 23->00.
REQ-017 buh/bum pulses with a=0 SHALL be ignored; simultaneous buh and bum SHALL both apply.
REQ-018 s0..s3 SHALL be registered: mux(a, a-digits, edig), one cycle latency.
REQ-019 match SHALL be edig==a-digits (all four); match_q SHALL register it; trigger = match & !match_q.
REQ-020 FSM states SHALL be IDLE, RING, SNOOZE.
REQ-021 IDLE->RING on trigger with en=1 and a=0; trigger otherwise discarded.
REQ-022 RING->IDLE on stop pulse, en=0, a=1, or RING_SEC elapsed since RING entry.
REQ-023 RING->SNOOZE on snz pulse; stop and snz same cycle: stop wins (->IDLE).
REQ-024 SNOOZE->RING after SNOOZE_SEC elapsed; SNOOZE->IDLE on stop, en=0 or a=1.
REQ-025 trigger in RING or SNOOZE SHALL be ignored.
REQ-026 A cycle prescaler (0..CLK_HZ-1) and seconds counter SHALL clear on every state entry; durations are exact: RING_SEC*CLK_HZ cycles in RING, SNOOZE_SEC*CLK_HZ in SNOOZE.
REQ-027 Tone divider SHALL be free-running, toggling tone every CLK_HZ/(2*TONE_HZ) cycles.
REQ-028 buzz SHALL be registered: tone AND state==RING AND prescaler < CLK_HZ/2 (0.5 s on / 0.5 s off, starting "on" at RING entry).
REQ-029 ringing = (state==RING), snoozing = (state==SNOOZE), registered from state.
REQ-030 Counter widths SHALL be $clog2-sized from parameters; no overflow within max durations.

Reset
REQ-031 rst_n=0 SHALL asynchronously set: state IDLE; a3:a2:a1:a0 = 0,6,0,0; s0..s3 = 0; buzz, ringing, snoozing, match_q, tone = 0; all counters and synchronizer/edge flops = 0.
REQ-032 Reset asserted mid-RING or mid-SNOOZE SHALL drop buzz same instant; after release, FSM in IDLE, no re-trigger until a fresh match edge.
REQ-033 match_q reset to 0: if edig equals 06:00 right after reset release with en=1, a=0, the alarm SHALL trigger.

Verification (CLK_HZ=20, TONE_HZ=5, RING_SEC=3, SNOOZE_SEC=2)
REQ-034 a=1, 10 bum presses from 00:58 -> a1:a0 = 0,8 (wraps 59->00); 3 buh presses from 22 -> a3:a2 = 0,1.
REQ-035 Alarm 07:30, en=1, e steps 07:29->07:30 -> ringing=1 two cycles later; buzz period 4 cycles for 10 cycles, low 10 cycles; ringing=0 after exactly 60 cycles.
REQ-036 In RING assert snz -> snoozing=1 3 cycles later; ringing returns after exactly 40 cycles, buzz restarts "on".
REQ-037 stop and snz rise same cycle in RING -> IDLE, snoozing never asserts; en=0 in SNOOZE -> IDLE next edge.
REQ-038 rst_n low mid-RING -> buzz=0 immediately, a-digits = 06:00; e held at 07:30 after release -> no ring.

Source files
------------

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: alarm-time editing, display mux, match detection and a
// ring/snooze state machine driving a gated square-wave buzzer.
module alarm_ctrl #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TONE_HZ    = 2000,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] e0,
    input  logic [3:0] e1,
    input  logic [3:0] e2,
    input  logic [3:0] e3,
    input  logic       a,
    input  logic       buh,
    input  logic       bum,
    input  logic       en,
    input  logic       stop,
    input  logic       snz,
    output logic [3:0] a0,
    output logic [3:0] a1,
    output logic [3:0] a2,
    output logic [3:0] a3,
    output logic [3:0] s0,
    output logic [3:0] s1,
    output logic [3:0] s2,
    output logic [3:0] s3,
    output logic       buzz,
    output logic       ringing,
    output logic       snoozing
);

    localparam int TONE_DIV = CLK_HZ / (2 * TONE_HZ);
    localparam int TW       = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam int PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int MAX_SEC  = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int SW       = (MAX_SEC > 1) ? $clog2(MAX_SEC + 1) : 1;

    localparam logic [TW-1:0] TONE_LAST   = TW'(TONE_DIV - 1);
    localparam logic [PW-1:0] PRESC_LAST  = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRESC_HALF  = PW'(CLK_HZ / 2);
    localparam logic [SW-1:0] RING_LAST   = SW'(RING_SEC - 1);
    localparam logic [SW-1:0] SNOOZE_LAST = SW'(SNOOZE_SEC - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } state_t;

    function automatic logic [7:0] inc_min(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            if (v[7:4] == 4'd5) begin
                r[7:4] = 4'd0;
            end else begin
                r[7:4] = v[7:4] + 4'd1;
            end
        end else begin
            r[3:0] = v[3:0] + 4'd1;
        end
        return r;
    endfunction

    function automatic logic [7:0] inc_hour(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (v == 8'h23) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = v[7:4] + 4'd1;
        end else begin
            r[3:0] = v[3:0] + 4'd1;
        end
        return r;
    endfunction

    // Button bit order: {snz, stop, buh, bum}
    logic [3:0]    r_btn_s1, r_btn_s2, r_btn_q;
    logic [3:0]    w_btn_p;
    logic [15:0]   r_edig;
    logic [7:0]    r_ahr, r_amin;
    logic [15:0]   r_sdig;
    logic          r_match_q;
    logic          w_match, w_trigger;
    state_t        r_state, w_next;
    logic [PW-1:0] r_presc;
    logic [SW-1:0] r_sec;
    logic [TW-1:0] r_tone_cnt;
    logic          r_tone;
    logic          w_ring_done, w_snooze_done;
    logic          r_buzz, r_ringing, r_snoozing;

    assign w_btn_p       = r_btn_s2 & ~r_btn_q;
    assign w_match       = (r_edig == {r_ahr, r_amin});
    assign w_trigger     = w_match & ~r_match_q;
    assign w_ring_done   = (r_sec == RING_LAST) && (r_presc == PRESC_LAST);
    assign w_snooze_done = (r_sec == SNOOZE_LAST) && (r_presc == PRESC_LAST);

    // Button synchronizers, edge-detect history and current-time capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_s1  <= 4'd0;
            r_btn_s2  <= 4'd0;
            r_btn_q   <= 4'd0;
            r_edig    <= 16'd0;
            r_match_q <= 1'b0;
        end else begin
            r_btn_s1  <= {snz, stop, buh, bum};
            r_btn_s2  <= r_btn_s1;
            r_btn_q   <= r_btn_s2;
            r_edig    <= {e3, e2, e1, e0};
            r_match_q <= w_match;
        end
    end

    // Alarm time editing; hour and minute fields wrap independently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ahr  <= 8'h06;
            r_amin <= 8'h00;
        end else begin
            if (a && w_btn_p[1]) begin
                r_ahr <= inc_hour(r_ahr);
            end
            if (a && w_btn_p[0]) begin
                r_amin <= inc_min(r_amin);
            end
        end
    end

    // Display register: alarm digits while editing, otherwise current time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sdig <= 16'd0;
        end else begin
            r_sdig <= a ? {r_ahr, r_amin} : r_edig;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; stop/disable/edit-mode take priority over snooze
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_trigger && en && !a) begin
                    w_next = ST_RING;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_RING: begin
                if (w_btn_p[2] || !en || a) begin
                    w_next = ST_IDLE;
                end else if (w_btn_p[3]) begin
                    w_next = ST_SNOOZE;
                end else if (w_ring_done) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_RING;
                end
            end
            ST_SNOOZE: begin
                if (w_btn_p[2] || !en || a) begin
                    w_next = ST_IDLE;
                end else if (w_snooze_done) begin
                    w_next = ST_RING;
                end else begin
                    w_next = ST_SNOOZE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Duration timer: restarts on every state change so durations are exact
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_sec   <= '0;
        end else if ((w_next != r_state) || (r_state == ST_IDLE)) begin
            r_presc <= '0;
            r_sec   <= '0;
        end else if (r_presc == PRESC_LAST) begin
            r_presc <= '0;
            r_sec   <= r_sec + {{(SW-1){1'b0}}, 1'b1};
        end else begin
            r_presc <= r_presc + {{(PW-1){1'b0}}, 1'b1};
        end
    end

    // Free-running tone divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tone_cnt <= '0;
            r_tone     <= 1'b0;
        end else if (r_tone_cnt == TONE_LAST) begin
            r_tone_cnt <= '0;
            r_tone     <= ~r_tone;
        end else begin
            r_tone_cnt <= r_tone_cnt + {{(TW-1){1'b0}}, 1'b1};
        end
    end

    // Registered status and buzzer outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buzz     <= 1'b0;
            r_ringing  <= 1'b0;
            r_snoozing <= 1'b0;
        end else begin
            r_buzz     <= r_tone && (r_state == ST_RING) && (r_presc < PRESC_HALF);
            r_ringing  <= (r_state == ST_RING);
            r_snoozing <= (r_state == ST_SNOOZE);
        end
    end

    assign {a3, a2} = r_ahr;
    assign {a1, a0} = r_amin;
    assign {s3, s2, s1, s0} = r_sdig;
    assign buzz     = r_buzz;
    assign ringing  = r_ringing;
    assign snoozing = r_snoozing;

endmodule
